seven_seg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for a NUM_DIGITS common-segment 7-segment display.

---
 rtl/seven_seg_scan_if.sv | 24 ++
 rtl/seven_seg_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_if.sv
// Bus bundle between the display-value logic (master) and the scan controller (slave).
interface seven_seg_scan_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      en;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      lz_suppress;
    logic [6:0]                seg_out;
    logic                      dp_out;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_done;

    modport master (
        output en, load, value, dp_in, lz_suppress,
        input  seg_out, dp_out, an, frame_done
    );

    modport slave (
        input  en, load, value, dp_in, lz_suppress,
        output seg_out, dp_out, an, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with slot blanking,
// frame-boundary double buffering and leading-zero suppression.
module seven_seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 1000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    seven_seg_scan_if.slave bus
);
    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic [VAL_W-1:0]      act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_done_q, frame_done_d;

    logic                  slot_end;
    logic                  frame_wrap;
    logic [3:0]            nibble;
    logic                  all_zero;
    logic [NUM_DIGITS-1:0] lz_mask;

    // Shared hex decoder, segments ordered {a,b,c,d,e,f,g}.
    function automatic logic [6:0] hex_to_7seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    assign slot_end   = (cnt_q == CNT_LAST);
    assign frame_wrap = slot_end && (idx_q == IDX_LAST);
    assign nibble     = act_val_q[{idx_q, 2'b00} +: 4];

    // Leading-zero mask: bit i set when every active nibble from the top down to i is zero.
    always_comb begin
        all_zero = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            all_zero   = all_zero & (act_val_q[4*i +: 4] == 4'h0);
            lz_mask[i] = all_zero;
        end
    end

    // Next-state: slot timer, buffers and the registered pin values.
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;
        seg_d        = '0;
        dp_d         = 1'b0;
        an_d         = '0;
        frame_done_d = 1'b0;

        if (bus.load) begin
            pend_val_d = bus.value;
            pend_dp_d  = bus.dp_in;
        end

        if (bus.en) begin
            if (slot_end) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            // A load coinciding with the wrap bypasses pending so it is not lost for a frame.
            if (frame_wrap) begin
                act_val_d    = bus.load ? bus.value : pend_val_q;
                act_dp_d     = bus.load ? bus.dp_in : pend_dp_q;
                frame_done_d = 1'b1;
            end

            if (cnt_q >= CNT_BLANK) begin
                an_d  = NUM_DIGITS'(1) << idx_q;
                dp_d  = act_dp_q[idx_q];
                seg_d = (bus.lz_suppress && lz_mask[idx_q]) ? 7'b0 : hex_to_7seg(nibble);
            end
        end
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            an_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.dp_out     = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: position-based reference model checked every cycle,
// plus hand-computed checkpoints.
module tb_seven_seg_scan_ctrl;
    localparam int unsigned ND    = 4;
    localparam int unsigned DIV   = 8;
    localparam int unsigned BLANK = 2;
    localparam int unsigned FRAME = ND * DIV;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seven_seg_scan_if #(.NUM_DIGITS(ND)) bus ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (DIV),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cur   = 0;

    // Model state: scan position counts enabled cycles since reset.
    int unsigned m_pos;
    logic [15:0] m_pv, m_av;
    logic [3:0]  m_pd, m_ad;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd;
    int unsigned mc, md;
    bit          ml;
    logic [3:0]  mnib;

    function automatic logic [6:0] hex_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    // Reference model: slot/digit derived from the scan position by division.
    always @(posedge clk) begin
        mc   = m_pos % DIV;
        md   = (m_pos / DIV) % ND;
        ml   = (m_pos % FRAME) == FRAME - 1;
        mnib = 4'(m_av >> (4 * md));
        if (rst) begin
            m_pos <= 0;
            m_pv  <= '0;
            m_pd  <= '0;
            m_av  <= '0;
            m_ad  <= '0;
            e_an  <= '0;
            e_seg <= '0;
            e_dp  <= 1'b0;
            e_fd  <= 1'b0;
        end else begin
            if (bus.load) begin
                m_pv <= bus.value;
                m_pd <= bus.dp_in;
            end
            e_an  <= '0;
            e_seg <= '0;
            e_dp  <= 1'b0;
            e_fd  <= 1'b0;
            if (bus.en) begin
                m_pos <= m_pos + 1;
                e_fd  <= ml;
                if (ml) begin
                    m_av <= bus.load ? bus.value : m_pv;
                    m_ad <= bus.load ? bus.dp_in : m_pd;
                end
                if (mc >= BLANK) begin
                    e_an <= 4'(1 << md);
                    e_dp <= m_ad[md];
                    if (bus.lz_suppress && md > 0 && (m_av >> (4 * md)) == 16'h0)
                        e_seg <= 7'b0;
                    else
                        e_seg <= hex_seg(mnib);
                end
            end
        end
    end

    task automatic check_model();
        n_cmp++;
        if (bus.an !== e_an || bus.seg_out !== e_seg || bus.dp_out !== e_dp || bus.frame_done !== e_fd) begin
            n_bad++;
            $display("FAIL cycle cur=%0d: got an=%b seg=%b dp=%b fd=%b, model wants an=%b seg=%b dp=%b fd=%b",
                     cur, bus.an, bus.seg_out, bus.dp_out, bus.frame_done, e_an, e_seg, e_dp, e_fd);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cur++;
        check_model();
    endtask

    task automatic step_to(input int p);
        while (cur < p) step();
    endtask

    task automatic chk_lit(input string name, input logic [3:0] an, input logic [6:0] seg,
                           input logic dp, input logic fd);
        n_cmp++;
        if (bus.an !== an || bus.seg_out !== seg || bus.dp_out !== dp || bus.frame_done !== fd) begin
            n_bad++;
            $display("FAIL %s: got an=%b seg=%b dp=%b fd=%b, required an=%b seg=%b dp=%b fd=%b",
                     name, bus.an, bus.seg_out, bus.dp_out, bus.frame_done, an, seg, dp, fd);
        end
        n_cmp++;
        if (e_an !== an || e_seg !== seg || e_dp !== dp || e_fd !== fd) begin
            n_bad++;
            $display("FAIL model_%s: model an=%b seg=%b dp=%b fd=%b, required an=%b seg=%b dp=%b fd=%b",
                     name, e_an, e_seg, e_dp, e_fd, an, seg, dp, fd);
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.en          = 1'b0;
        bus.load        = 1'b0;
        bus.value       = 16'h0;
        bus.dp_in       = 4'b0;
        bus.lz_suppress = 1'b0;
        repeat (3) step();
        chk_lit("reset", 4'b0, 7'b0, 1'b0, 1'b0);

        // Release with ABCD loaded; it becomes active at the first frame boundary.
        rst       = 1'b0;
        bus.en    = 1'b1;
        bus.load  = 1'b1;
        bus.value = 16'hABCD;
        cur       = -1;
        step();
        bus.load = 1'b0;
        step_to(32); chk_lit("f1_blank", 4'b0000, 7'b0000000, 1'b0, 1'b0);
        step_to(34); chk_lit("d0_D",     4'b0001, 7'b0111101, 1'b0, 1'b0);
        step_to(42); chk_lit("d1_C",     4'b0010, 7'b1001110, 1'b0, 1'b0);
        step_to(50); chk_lit("d2_B",     4'b0100, 7'b0011111, 1'b0, 1'b0);
        step_to(58); chk_lit("d3_A",     4'b1000, 7'b1110111, 1'b0, 1'b0);
        step_to(62); chk_lit("pre_fd",   4'b1000, 7'b1110111, 1'b0, 1'b0);
        step_to(63); chk_lit("fd",       4'b1000, 7'b1110111, 1'b0, 1'b1);
        step_to(64); chk_lit("post_fd",  4'b0000, 7'b0000000, 1'b0, 1'b0);

        // Mid-frame load must not tear the current frame.
        step_to(73);
        bus.load  = 1'b1;
        bus.value = 16'h1234;
        step();
        bus.load = 1'b0;
        step_to(76); chk_lit("still_C", 4'b0010, 7'b1001110, 1'b0, 1'b0);
        step_to(82); chk_lit("still_B", 4'b0100, 7'b0011111, 1'b0, 1'b0);
        step_to(98); chk_lit("new_4",   4'b0001, 7'b0110011, 1'b0, 1'b0);

        // Leading-zero suppression.
        step_to(100);
        bus.lz_suppress = 1'b1;
        bus.load        = 1'b1;
        bus.value       = 16'h000F;
        step();
        bus.load = 1'b0;
        step_to(130); chk_lit("lz_F",  4'b0001, 7'b1000111, 1'b0, 1'b0);
        step_to(138); chk_lit("lz_d1", 4'b0010, 7'b0000000, 1'b0, 1'b0);
        step_to(154); chk_lit("lz_d3", 4'b1000, 7'b0000000, 1'b0, 1'b0);
        step_to(155);
        bus.load  = 1'b1;
        bus.value = 16'h0000;
        step();
        bus.load = 1'b0;
        step_to(162); chk_lit("lz_zero_d0", 4'b0001, 7'b1111110, 1'b0, 1'b0);
        step_to(170); chk_lit("lz_zero_d1", 4'b0010, 7'b0000000, 1'b0, 1'b0);

        // Decimal point on digit 2 only.
        step_to(175);
        bus.lz_suppress = 1'b0;
        bus.load        = 1'b1;
        bus.value       = 16'h0000;
        bus.dp_in       = 4'b0100;
        step();
        bus.load = 1'b0;
        step_to(202); chk_lit("dp_d1",    4'b0010, 7'b1111110, 1'b0, 1'b0);
        step_to(208); chk_lit("dp_blank", 4'b0000, 7'b0000000, 1'b0, 1'b0);
        step_to(210); chk_lit("dp_d2",    4'b0100, 7'b1111110, 1'b1, 1'b0);

        // Pause at cnt=5 of digit 1 for three cycles, then resume.
        step_to(236);
        bus.en = 1'b0;
        step_to(237); chk_lit("en_off",  4'b0000, 7'b0000000, 1'b0, 1'b0);
        step_to(239); chk_lit("en_hold", 4'b0000, 7'b0000000, 1'b0, 1'b0);
        bus.en = 1'b1;
        step_to(240); chk_lit("resume",      4'b0010, 7'b1111110, 1'b0, 1'b0);
        step_to(242); chk_lit("resume_last", 4'b0010, 7'b1111110, 1'b0, 1'b0);
        step_to(243); chk_lit("next_blank",  4'b0000, 7'b0000000, 1'b0, 1'b0);
        step_to(245); chk_lit("d2_after",    4'b0100, 7'b1111110, 1'b1, 1'b0);

        // Reset mid digit 2 with a simultaneous load; the load must be discarded.
        step_to(276);
        rst       = 1'b1;
        bus.load  = 1'b1;
        bus.value = 16'h5555;
        step();
        chk_lit("rst_mid", 4'b0000, 7'b0000000, 1'b0, 1'b0);
        rst      = 1'b0;
        bus.load = 1'b0;
        cur      = -1;
        step_to(0);  chk_lit("rst_blank", 4'b0000, 7'b0000000, 1'b0, 1'b0);
        step_to(2);  chk_lit("rst_d0",    4'b0001, 7'b1111110, 1'b0, 1'b0);
        step_to(34); chk_lit("rst_pend0", 4'b0001, 7'b1111110, 1'b0, 1'b0);
        step_to(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
